// File: rtl/imem_refill_arbiter.sv
// Round-robin arbiter sequencing single-outstanding 4-beat instruction line
// refills between NUM_REQ requesters and the instruction-memory model.
module imem_refill_arbiter #(
  parameter int unsigned LINE_SIZE = 128,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*26-1:0]  req_addr_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  output logic [LINE_SIZE-1:0]   resp_data_o,
  output logic [1:0]             resp_seq_o,
  output logic                   resp_last_o,
  output logic [25:0]            mem_addr_o,
  output logic                   mem_valid_o,
  input  logic [LINE_SIZE-1:0]   mem_line_i,
  input  logic                   mem_valid_i,
  input  logic [1:0]             mem_seq_num_i,
  output logic                   busy_o,
  output logic                   err_seq_o,
  output logic                   err_spurious_o,
  output logic                   timeout_o
);

  localparam int unsigned AW = 26;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] REQ_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   prio_q;
  logic [PW-1:0]   owner_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      beat_q;
  logic [TW-1:0]   tmo_q;
  logic            err_seq_q;
  logic            err_spur_q;

  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   prio_next;
  logic            beat_fire;
  logic            seq_err;
  logic            spurious;
  logic [AW-1:0]   req_addr_a [NUM_REQ];

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_addr_a[r] = req_addr_i[r*AW +: AW];
    end
  end

  // First asserted requester scanning upward from prio_q, wrapping at NUM_REQ.
  always_comb begin : arb
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(prio_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid_i[PW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    if (grant_idx == REQ_LAST) prio_next = '0;
    else                       prio_next = grant_idx + PW'(1);
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    mem_valid_o  = 1'b0;
    resp_valid_o = '0;
    resp_data_o  = '0;
    resp_seq_o   = '0;
    resp_last_o  = 1'b0;
    timeout_o    = 1'b0;
    beat_fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          req_ready_o[grant_idx] = 1'b1;
          state_d                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_valid_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid_i) begin
          beat_fire             = 1'b1;
          resp_valid_o[owner_q] = 1'b1;
          resp_data_o           = mem_line_i;
          resp_seq_o            = mem_seq_num_i;
          resp_last_o           = (beat_q == 2'd3);
        end
        // A final beat landing on the expiry cycle wins over the timeout.
        if (mem_valid_i && beat_q == 2'd3) begin
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          timeout_o = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign seq_err  = beat_fire && (mem_seq_num_i != beat_q);
  assign spurious = mem_valid_i && (state_q != S_WAIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      prio_q     <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      err_seq_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_any) begin
        owner_q <= grant_idx;
        addr_q  <= req_addr_a[grant_idx];
        prio_q  <= prio_next;
      end
      if (state_q == S_ISSUE) begin
        beat_q <= '0;
        tmo_q  <= '0;
      end
      if (state_q == S_WAIT) begin
        tmo_q <= tmo_q + TW'(1);
        if (beat_fire) beat_q <= beat_q + 2'd1;
      end
      if (seq_err)  err_seq_q  <= 1'b1;
      if (spurious) err_spur_q <= 1'b1;
    end
  end

  assign mem_addr_o     = addr_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_seq_o      = err_seq_q;
  assign err_spurious_o = err_spur_q;

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Directed bench for imem_refill_arbiter: single refill, contention, sequence
// error, timeout, final-beat-at-expiry and reset mid-transaction.
module tb_imem_refill_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [1:0]   req_valid_i = '0;
  logic [51:0]  req_addr_i = '0;
  logic [1:0]   req_ready_o;
  logic [1:0]   resp_valid_o;
  logic [127:0] resp_data_o;
  logic [1:0]   resp_seq_o;
  logic         resp_last_o;
  logic [25:0]  mem_addr_o;
  logic         mem_valid_o;
  logic [127:0] mem_line_i = '0;
  logic         mem_valid_i = 1'b0;
  logic [1:0]   mem_seq_num_i = '0;
  logic         busy_o;
  logic         err_seq_o;
  logic         err_spurious_o;
  logic         timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  imem_refill_arbiter #(.LINE_SIZE(128), .NUM_REQ(2), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_seq_o(resp_seq_o),
    .resp_last_o(resp_last_o), .mem_addr_o(mem_addr_o), .mem_valid_o(mem_valid_o),
    .mem_line_i(mem_line_i), .mem_valid_i(mem_valid_i), .mem_seq_num_i(mem_seq_num_i),
    .busy_o(busy_o), .err_seq_o(err_seq_o), .err_spurious_o(err_spurious_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".req_ready"},  128'(req_ready_o),    128'(0));
    chk({tag, ".resp_valid"}, 128'(resp_valid_o),   128'(0));
    chk({tag, ".resp_data"},  resp_data_o,          128'(0));
    chk({tag, ".resp_seq"},   128'(resp_seq_o),     128'(0));
    chk({tag, ".resp_last"},  128'(resp_last_o),    128'(0));
    chk({tag, ".mem_addr"},   128'(mem_addr_o),     128'(0));
    chk({tag, ".mem_valid"},  128'(mem_valid_o),    128'(0));
    chk({tag, ".busy"},       128'(busy_o),         128'(0));
    chk({tag, ".err_seq"},    128'(err_seq_o),      128'(0));
    chk({tag, ".err_spur"},   128'(err_spurious_o), 128'(0));
    chk({tag, ".timeout"},    128'(timeout_o),      128'(0));
  endtask

  function automatic logic [127:0] beat_line(input logic [25:0] a, input logic [1:0] b);
    logic [31:0] w;
    w = {4'hA, b, a};
    return {4{w}};
  endfunction

  // Grant check in IDLE, then ISSUE, dly idle WAIT cycles, 4 in-order beats, GAP, IDLE.
  task automatic txn(input string tag, input logic [1:0] exp_grant, input logic [25:0] exp_addr,
                     input int unsigned dly, input bit drop);
    logic [1:0] b;
    #1;
    chk({tag, ".grant"}, 128'(req_ready_o), 128'(exp_grant));
    step();
    if (drop) req_valid_i = '0;
    #1;
    chk({tag, ".mem_valid"}, 128'(mem_valid_o), 128'(1));
    chk({tag, ".mem_addr"},  128'(mem_addr_o),  128'(exp_addr));
    chk({tag, ".ready_issue"}, 128'(req_ready_o), 128'(0));
    step();
    chk({tag, ".mem_valid_wait"}, 128'(mem_valid_o), 128'(0));
    repeat (dly) step();
    for (int unsigned i = 0; i < 4; i++) begin
      b = 2'(i);
      mem_valid_i   = 1'b1;
      mem_seq_num_i = b;
      mem_line_i    = beat_line(exp_addr, b);
      #1;
      chk({tag, ".resp_valid"}, 128'(resp_valid_o), 128'(exp_grant));
      chk({tag, ".resp_seq"},   128'(resp_seq_o),   128'(b));
      chk({tag, ".resp_last"},  128'(resp_last_o),  128'(i == 3));
      chk({tag, ".resp_data"},  resp_data_o,        beat_line(exp_addr, b));
      chk({tag, ".addr_hold"},  128'(mem_addr_o),   128'(exp_addr));
      chk({tag, ".no_tmo"},     128'(timeout_o),    128'(0));
      step();
    end
    mem_valid_i = 1'b0;
    mem_line_i  = '0;
    #1;
    chk({tag, ".gap_busy"},  128'(busy_o),       128'(1));
    chk({tag, ".gap_ready"}, 128'(req_ready_o),  128'(0));
    chk({tag, ".gap_resp"},  128'(resp_valid_o), 128'(0));
    step();
    chk({tag, ".idle_busy"}, 128'(busy_o), 128'(0));
  endtask

  initial begin
    // Reset
    step(); step();
    rst_i = 1'b0;
    #1;
    chk_zero_outs("reset");

    // Single request, memory DELAY 20
    req_addr_i[25:0] = 26'h0000123;
    req_valid_i      = 2'b01;
    txn("single", 2'b01, 26'h0000123, 20, 1'b1);

    // Contention from reset: grants alternate 0,1,0,1
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_addr_i  = {26'h2BCDEF0, 26'h1234567};
    req_valid_i = 2'b11;
    txn("cont0", 2'b01, 26'h1234567, 2, 1'b0);
    txn("cont1", 2'b10, 26'h2BCDEF0, 2, 1'b0);
    txn("cont2", 2'b01, 26'h1234567, 2, 1'b0);
    txn("cont3", 2'b10, 26'h2BCDEF0, 2, 1'b0);
    req_valid_i = '0;

    // Sequence error: beats 0,2 then 2,3
    req_addr_i[25:0] = 26'h0000ABC;
    req_valid_i      = 2'b01;
    #1;
    chk("seq.grant", 128'(req_ready_o), 128'(2'b01));
    step();
    req_valid_i = '0;
    step();
    mem_valid_i = 1'b1; mem_seq_num_i = 2'd0; mem_line_i = beat_line(26'h0000ABC, 2'd0);
    #1;
    chk("seq.b0_seq", 128'(resp_seq_o), 128'(0));
    step();
    mem_seq_num_i = 2'd2; mem_line_i = beat_line(26'h0000ABC, 2'd2);
    #1;
    chk("seq.bad_valid", 128'(resp_valid_o), 128'(2'b01));
    chk("seq.bad_seq",   128'(resp_seq_o),   128'(2));
    chk("seq.bad_data",  resp_data_o,        beat_line(26'h0000ABC, 2'd2));
    chk("seq.err_before", 128'(err_seq_o),   128'(0));
    step();
    chk("seq.err_set", 128'(err_seq_o), 128'(1));
    step();
    mem_seq_num_i = 2'd3;
    #1;
    chk("seq.last", 128'(resp_last_o), 128'(1));
    step();
    mem_valid_i = 1'b0;
    step();
    chk("seq.idle", 128'(busy_o), 128'(0));
    chk("seq.err_sticky", 128'(err_seq_o), 128'(1));

    // Timeout: memory never answers; WAIT spans 64 cycles
    req_addr_i[25:0] = 26'h0000777;
    req_valid_i      = 2'b01;
    #1;
    chk("tmo.grant", 128'(req_ready_o), 128'(2'b01));
    step();
    req_valid_i = '0;
    step();
    repeat (62) step();
    chk("tmo.early", 128'(timeout_o), 128'(0));
    step();
    chk("tmo.pulse", 128'(timeout_o), 128'(1));
    step();
    chk("tmo.gap_low",  128'(timeout_o), 128'(0));
    chk("tmo.gap_busy", 128'(busy_o),    128'(1));
    step();
    chk("tmo.idle", 128'(busy_o), 128'(0));
    chk("tmo.no_spur_yet", 128'(err_spurious_o), 128'(0));
    // Late beat in IDLE is dropped and flagged
    mem_valid_i = 1'b1; mem_seq_num_i = 2'd0; mem_line_i = beat_line(26'h0000777, 2'd0);
    #1;
    chk("late.resp_valid", 128'(resp_valid_o), 128'(0));
    chk("late.resp_data",  resp_data_o,        128'(0));
    step();
    mem_valid_i = 1'b0; mem_line_i = '0;
    #1;
    chk("late.err_spur", 128'(err_spurious_o), 128'(1));
    // Normal request after timeout; pointer sits at requester 1
    req_addr_i  = {26'h3000001, 26'h0000000};
    req_valid_i = 2'b10;
    txn("post_tmo", 2'b10, 26'h3000001, 3, 1'b1);

    // Final beat on the expiry cycle counts as completion
    req_addr_i[25:0] = 26'h0055AA5;
    req_valid_i      = 2'b01;
    txn("edge_tmo", 2'b01, 26'h0055AA5, 60, 1'b1);

    // Reset during WAIT after beat 1
    req_addr_i[25:0] = 26'h0F0F0F0;
    req_valid_i      = 2'b01;
    #1;
    chk("rstw.grant", 128'(req_ready_o), 128'(2'b01));
    step();
    req_valid_i = '0;
    step();
    mem_valid_i = 1'b1; mem_seq_num_i = 2'd0; mem_line_i = beat_line(26'h0F0F0F0, 2'd0);
    step();
    mem_seq_num_i = 2'd1; mem_line_i = beat_line(26'h0F0F0F0, 2'd1);
    #1;
    chk("rstw.b1_valid", 128'(resp_valid_o), 128'(2'b01));
    step();
    rst_i = 1'b1;
    mem_seq_num_i = 2'd2; mem_line_i = beat_line(26'h0F0F0F0, 2'd2);
    step();
    rst_i = 1'b0;
    mem_seq_num_i = 2'd3; mem_line_i = beat_line(26'h0F0F0F0, 2'd3);
    #1;
    chk_zero_outs("rstw");
    step();
    mem_valid_i = 1'b0; mem_line_i = '0;
    #1;
    chk("rstw.err_spur", 128'(err_spurious_o), 128'(1));
    chk("rstw.err_seq",  128'(err_seq_o),      128'(0));
    req_valid_i = 2'b11;
    #1;
    chk("rstw.prio_restart", 128'(req_ready_o), 128'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_refill_arbiter.md
# imem_refill_arbiter

Arbitrates between `NUM_REQ` instruction-line requesters (I-cache refill, instruction prefetcher, …) for the single perfect instruction-memory model. It sequences one outstanding line request at a time: a one-cycle request pulse, a held address, collection of the 4 returned 128-bit beats, and a mandatory one-cycle gap before the next request. Beats are steered to the owning requester. Sequence-number mismatches, spurious beats and timeouts are flagged. The block sits between the front-end requesters and the memory model in the simulation top.

## Interface
**Parameters**
- `LINE_SIZE`, 128 — width of one returned beat.
- `NUM_REQ`, 2 — number of requesters; must be ≥ 2.
- `TIMEOUT`, 64 — maximum cycles in WAIT before abort; must exceed the memory DELAY + 4.

**Ports**
- `clk_i` input 1 — single clock.
- `rst_i` input 1 — reset; synchronous, active-high.
- `req_valid_i` input `NUM_REQ` — per-requester line request.
- `req_addr_i` input `NUM_REQ`×26 — per-requester line address.
- `req_ready_o` output `NUM_REQ` — one-hot grant; the request is accepted this cycle.
- `resp_valid_o` output `NUM_REQ` — beat valid, one-hot to the owner.
- `resp_data_o` output `LINE_SIZE` — beat data, shared by all requesters.
- `resp_seq_o` output 2 — beat index 0..3.
- `resp_last_o` output 1 — high on beat 3.
- `mem_addr_o` output 26 — address to memory; held for the whole transaction.
- `mem_valid_o` output 1 — request pulse to memory.
- `mem_line_i` input `LINE_SIZE` — memory beat data.
- `mem_valid_i` input 1 — memory beat valid.
- `mem_seq_num_i` input 2 — memory beat index.
- `busy_o` output 1 — state is not IDLE.
- `err_seq_o` output 1 — sticky; a beat index mismatch occurred.
- `err_spurious_o` output 1 — sticky; a beat arrived outside WAIT.
- `timeout_o` output 1 — one-cycle pulse on abort.

## Operation
**FSM states:** IDLE → ISSUE → WAIT → GAP → IDLE.
- **IDLE**
  - `req_ready_o` is asserted combinationally to the round-robin winner among `req_valid_i`.
  - On accept: latch the owner index and `req_addr_i[owner]` into `addr_q`, then go to ISSUE.
- **ISSUE**
  - `mem_valid_o` = 1 for exactly one cycle.
  - Clear the beat counter `beat_q` and the timeout counter.
  - Go to WAIT.
- **WAIT**
  - `mem_valid_o` = 0.
  - Each `mem_valid_i` cycle is forwarded combinationally: `resp_valid_o[owner]` = 1, `resp_data_o` = `mem_line_i`, `resp_seq_o` = `mem_seq_num_i`, `resp_last_o` = (`beat_q` == 3).
  - If `mem_seq_num_i` ≠ `beat_q`, set `err_seq_o`; the beat is still forwarded.
  - `beat_q` increments on each beat. After beat 3 is accepted, go to GAP.
  - The timeout counter increments every WAIT cycle. When it reaches `TIMEOUT`-1 without completion: pulse `timeout_o`, go to GAP, and deliver no further beats.
- **GAP**
  - One cycle with no request. This guarantees the memory drops its internal request state before the next pulse.
  - Then go to IDLE.
- **Spurious beats:** `mem_valid_i` in any state other than WAIT is dropped (no `resp_valid_o`) and sets `err_spurious_o`.
- **Round robin:**
  - A pointer `prio_q` is reset to 0.
  - The winner is the first asserted requester scanning from `prio_q` upward with wrap.
  - After a grant to requester i, `prio_q` = (i+1) mod `NUM_REQ`.
- **`mem_addr_o`** = `addr_q` in all states. It is never changed outside IDLE.
- **Requesters not granted** must hold `req_valid_i` and `req_addr_i`. The arbiter keeps no queue.

## Timing
- **Reset** (`rst_i` high at a clock edge):
  - State = IDLE, `prio_q` = 0, `addr_q` = 0, `beat_q` = 0.
  - All outputs are 0 from the next cycle, including both sticky errors.
  - Reset mid-transaction abandons the transaction; later memory beats count as spurious.
- **Request path:**
  - Accept at cycle t → `mem_valid_o` at t+1 → earliest beat at t+2.
  - With memory DELAY=20, beats arrive at t+22..t+25, one per cycle.
- **Response path:** combinational from `mem_*_i` to `resp_*_o`; zero added latency.
- **Turnaround:** last beat at cycle u → GAP at u+1 → IDLE at u+2, when the next grant is possible. Back-to-back request spacing is therefore ≥ beats + 3 cycles.
- **Idle outputs:** `resp_data_o` = 0 whenever no `resp_valid_o` bit is set.
- **`req_ready_o`** is 0 in every state except IDLE.
- **Simultaneous events:**
  - A beat-3 arrival in the same cycle the timeout expires counts as completion; no `timeout_o` pulse.
  - `rst_i` overrides everything.

## Test plan
- **Single request:** req0, addr 0x0000123, memory DELAY 20.
  - Grant at t, `mem_valid_o` at t+1.
  - 4 beats on `resp_valid_o[0]` with seq 0,1,2,3; `resp_last_o` on seq 3.
  - `busy_o` falls 2 cycles after the last beat.
- **Contention:** req0 and req1 held continuously from reset.
  - Grants alternate 0,1,0,1.
  - Each grant follows the prior transaction's GAP cycle.
  - `mem_addr_o` is stable through each transaction.
- **Sequence error:** inject a beat sequence 0,2,… → the beat is forwarded with `resp_seq_o`=2 and `err_seq_o` goes to 1 and stays set.
- **Timeout:** stub memory that never responds, `TIMEOUT`=64 → `timeout_o` pulses once.
  - A subsequent request is granted normally.
  - A late beat sets `err_spurious_o` and is not forwarded.
- **Reset during WAIT:** assert `rst_i` after beat 1.
  - All outputs are 0 the next cycle.
  - Remaining beats set `err_spurious_o`, since it is re-enabled after reset.
  - `prio_q` restarts at requester 0.
